control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Moore FSM sequencing the 16x16 register file, data memory, ALU and PC/IR of the lab processor.
//  Fetches one instruction per pass and drives the register-file read/write ports and the write-data mux.
//  Sits between the instruction register and the datapath (register file + ALU + data RAM).
// PARAMETERS
//  DA_W   8   data-memory address width (IR[11:4] for LOAD/STORE)
// PORTS
//  clock      in   1   system clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  ir         in   16  current instruction register contents
//  pc_clr     out  1   clear program counter
//  pc_up      out  1   increment program counter
//  ir_ld      out  1   load IR from instruction memory
//  d_addr     out  DA_W data-memory address
//  d_wr       out  1   data-memory write enable
//  rf_s       out  2   w_data mux: 00 ALU, 01 memory, 10 immediate
//  rf_imm     out  8   immediate for rf_s=10 (zero-extended by datapath)
//  rf_w_addr  out  4   register-file write address
//  rf_w_wr    out  1   register-file write enable
//  rf_ra_addr out  4   A read address;  rf_ra_rd out 1  A read enable
//  rf_rb_addr out  4   B read address;  rf_rb_rd out 1  B read enable
//  alu_s      out  3   ALU op: 000 pass-zero, 001 A+B, 010 A-B
//  state      out  4   current state code (debug)
// BEHAVIOUR
//  Opcode IR[15:12]: 0 NOOP, 1 STORE mem[IR[11:4]]<=R[IR[3:0]], 2 LOAD R[IR[3:0]]<=mem[IR[11:4]],
//   3 ADD R[IR[3:0]]<=R[IR[11:8]]+R[IR[7:4]], 4 SUB same with minus, 5 HALT, 6 LOADC (macro only).
//  States/codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8,
//   HALT 9, LOADC 10. Unused codes -> INIT next cycle.
//  Transitions: INIT->FETCH; FETCH->DECODE; DECODE->{per opcode}; LOAD_A->LOAD_B; NOOP, LOAD_B,
//   STORE, ADD, SUB, LOADC ->FETCH; HALT->HALT until reset.
//  Undefined opcodes (7..F, and 6 without macro) decode to NOOP.
//  Outputs are pure functions of registered state and ir; every output defaults to 0 in every state.
//  INIT: pc_clr=1. FETCH: ir_ld=1, pc_up=1. DECODE: all strobes 0.
//  LOAD_A: d_addr=IR[11:4], rf_s=01, rf_w_addr=IR[3:0] (1-cycle RAM read latency).
//  LOAD_B: as LOAD_A plus rf_w_wr=1.
//  STORE: d_addr=IR[11:4], d_wr=1, rf_ra_addr=IR[3:0], rf_ra_rd=1.
//  ADD/SUB: rf_ra_addr=IR[11:8], rf_rb_addr=IR[7:4], both rd=1, alu_s=001/010, rf_s=00,
//   rf_w_addr=IR[3:0], rf_w_wr=1 (write at end of the single execute cycle).
//  Read enables are asserted only when that port is consumed, so undriven ports stay high-Z.
//  Latency per instr incl. fetch/decode: NOOP/STORE/ADD/SUB/LOADC 3, LOAD 4 cycles.
//  Reset (any state, incl. LOAD_A or HALT): next state INIT; no write strobe in that cycle's successor.
//  While reset is high state holds INIT; state=0, pc_clr=1, all other outputs 0.
//  Same-register read/write (e.g. ADD R1=R1+R1): legal, reads pre-edge value.
// CONFIGURATION
//  CU_LOADC_EN defined: opcode 6 -> LOADC: rf_s=10, rf_imm=IR[7:0], rf_w_addr=IR[11:8], rf_w_wr=1.
//  Not defined: opcode 6 is NOOP, state 10 unreachable, rf_s never 10, rf_imm tied 0.
// TESTING
//  T1 reset 3 cycles, release -> state 0,1,2 sequence; pc_clr=1 only in INIT, ir_ld/pc_up=1 only in FETCH.
//  T2 ir=16'h2A53 (LOAD R3<-mem[0xA5]) -> LOAD_A then LOAD_B; d_addr=0xA5, rf_s=01, rf_w_wr=1 only LOAD_B.
//  T3 ir=16'h3124 (ADD R4=R1+R2) -> ADD state: ra=1, rb=2, alu_s=001, rf_w_addr=4, rf_w_wr=1, 3 cycles.
//  T4 ir=16'h1B07 (STORE mem[0xB0]<-R7) -> d_wr=1, d_addr=0xB0, ra=7 rd=1, rf_w_wr=0.
//  T5 ir=16'h5000 -> HALT held 20 cycles, no strobes; reset -> INIT; reset in LOAD_A -> no rf_w_wr.
//  T6 ir=16'h6C3F: with CU_LOADC_EN rf_s=10, rf_imm=0x3F, w_addr=0xC, wr=1; without -> NOOP, no wr.

Source files
------------

// File: rtl/control_unit.sv
// Moore sequencer for the lab processor: fetch, decode and execute of one instruction per pass.
// Optional LOADC (opcode 6) instruction is built only when CU_LOADC_EN is defined.
module control_unit #(
    parameter int unsigned DA_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [15:0]     ir,
    output logic            pc_clr,
    output logic            pc_up,
    output logic            ir_ld,
    output logic [DA_W-1:0] d_addr,
    output logic            d_wr,
    output logic [1:0]      rf_s,
    output logic [7:0]      rf_imm,
    output logic [3:0]      rf_w_addr,
    output logic            rf_w_wr,
    output logic [3:0]      rf_ra_addr,
    output logic            rf_ra_rd,
    output logic [3:0]      rf_rb_addr,
    output logic            rf_rb_rd,
    output logic [2:0]      alu_s,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StLoadA  = 4'd4,
        StLoadB  = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9,
        StLoadc  = 4'd10
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StInit;
        unique case (state_q)
            StInit:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (ir[15:12])
                    4'h0:    state_d = StNoop;
                    4'h1:    state_d = StStore;
                    4'h2:    state_d = StLoadA;
                    4'h3:    state_d = StAdd;
                    4'h4:    state_d = StSub;
                    4'h5:    state_d = StHalt;
`ifdef CU_LOADC_EN
                    4'h6:    state_d = StLoadc;
`endif
                    default: state_d = StNoop;
                endcase
            end
            StNoop:   state_d = StFetch;
            StLoadA:  state_d = StLoadB;
            StLoadB:  state_d = StFetch;
            StStore:  state_d = StFetch;
            StAdd:    state_d = StFetch;
            StSub:    state_d = StFetch;
            StHalt:   state_d = StHalt;
`ifdef CU_LOADC_EN
            StLoadc:  state_d = StFetch;
`endif
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 2'b00;
        rf_imm     = 8'h00;
        rf_w_addr  = 4'h0;
        rf_w_wr    = 1'b0;
        rf_ra_addr = 4'h0;
        rf_ra_rd   = 1'b0;
        rf_rb_addr = 4'h0;
        rf_rb_rd   = 1'b0;
        alu_s      = 3'b000;
        case (state_q)
            StInit: pc_clr = 1'b1;
            StFetch: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            // RAM read takes one cycle, so the write-back happens in the second load state.
            StLoadA, StLoadB: begin
                d_addr    = DA_W'(ir[11:4]);
                rf_s      = 2'b01;
                rf_w_addr = ir[3:0];
                rf_w_wr   = (state_q == StLoadB);
            end
            StStore: begin
                d_addr     = DA_W'(ir[11:4]);
                d_wr       = 1'b1;
                rf_ra_addr = ir[3:0];
                rf_ra_rd   = 1'b1;
            end
            StAdd, StSub: begin
                rf_ra_addr = ir[11:8];
                rf_ra_rd   = 1'b1;
                rf_rb_addr = ir[7:4];
                rf_rb_rd   = 1'b1;
                alu_s      = (state_q == StAdd) ? 3'b001 : 3'b010;
                rf_s       = 2'b00;
                rf_w_addr  = ir[3:0];
                rf_w_wr    = 1'b1;
            end
`ifdef CU_LOADC_EN
            StLoadc: begin
                rf_s      = 2'b10;
                rf_imm    = ir[7:0];
                rf_w_addr = ir[11:8];
                rf_w_wr   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
